lbp_hist: RTL and testbench

- Downstream consumer of the LBP stage. Accepts the lbp_valid/lbp_addr/lbp_data pixel stream and builds a 256-bin histogram of LBP codes for interior pixels.
- When the LBP stage raises finish, the block streams out all 256 bins over a valid/ready interface, clearing each bin as it is read.
- Signals completion and exposes sticky error flags for the pixel-statistics path.

---
 rtl/lbp_hist.sv | 150 +++++++++++++++
 tb/tb_lbp_hist.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes for interior pixels.
// Samples arrive on lbp_valid/lbp_addr/lbp_data while in ACCUM. Border pixels
// are rejected and flagged. Once lbp_finish rises, the bins are streamed out
// in index order. Each bin is cleared as it is read, so the block ends the dump
// with an all-zero histogram.
//
// Handshake (hist_*): a word transfers on a rising edge where hist_valid and
// hist_ready are both high. While hist_valid is high and hist_ready is low,
// hist_bin, hist_count and hist_last hold stable. hist_valid never drops
// before its word transfers.
module lbp_hist #(
  parameter int CNT_W = 14,
  parameter int IMG_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             lbp_finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_last,
  output logic             hist_done,
  output logic [CNT_W-1:0] total_count,
  output logic             border_err,
  output logic             late_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DUMP  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [13:0]      IMG_W_A = 14'(IMG_W);
  localparam logic [13:0]      EDGE_A  = 14'(IMG_W - 1);

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             border_q, border_d;
  logic             late_q, late_d;
  logic [CNT_W-1:0] bin_q [256];

  // At most one bin is written per cycle: an increment in ACCUM or a clear in DUMP.
  logic             bin_we;
  logic [7:0]       bin_wa;
  logic [CNT_W-1:0] bin_wd;

  logic [13:0] row;
  logic [13:0] col;
  logic        is_border;

  // Border test on the sample address.
  always_comb begin
    row       = lbp_addr / IMG_W_A;
    col       = lbp_addr % IMG_W_A;
    is_border = (row == 14'd0) || (row == EDGE_A) ||
                (col == 14'd0) || (col == EDGE_A);
  end

  // Next-state, bin write port and stream outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    total_d    = total_q;
    border_d   = border_q;
    late_d     = late_q;
    bin_we     = 1'b0;
    bin_wa     = lbp_data;
    bin_wd     = '0;
    hist_valid = 1'b0;
    hist_bin   = 8'd0;
    hist_count = '0;
    hist_last  = 1'b0;
    hist_done  = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (lbp_valid) begin
          if (is_border) begin
            border_d = 1'b1;
          end else begin
            bin_we  = 1'b1;
            bin_wa  = lbp_data;
            bin_wd  = (bin_q[lbp_data] == CNT_MAX) ? CNT_MAX
                                                   : bin_q[lbp_data] + CNT_W'(1);
            total_d = (total_q == CNT_MAX) ? CNT_MAX : total_q + CNT_W'(1);
          end
        end
        if (lbp_finish) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        hist_valid = 1'b1;
        hist_bin   = idx_q;
        hist_count = bin_q[idx_q];
        hist_last  = (idx_q == 8'd255);
        if (lbp_valid) late_d = 1'b1;
        if (hist_ready) begin
          bin_we = 1'b1;
          bin_wa = idx_q;
          bin_wd = '0;
          idx_d  = idx_q + 8'd1;
          if (idx_q == 8'd255) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        hist_done = 1'b1;
        if (lbp_valid) late_d = 1'b1;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_ACCUM;
      idx_q    <= 8'd0;
      total_q  <= '0;
      border_q <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      total_q  <= total_d;
      border_q <= border_d;
      late_q   <= late_d;
    end
  end

  // Bin storage; a single write per cycle means no read-modify-write hazard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) bin_q[i] <= '0;
    end else if (bin_we) begin
      bin_q[bin_wa] <= bin_wd;
    end
  end

  assign total_count = total_q;
  assign border_err  = border_q;
  assign late_err    = late_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: accumulation, border rejection, saturation,
// streamed dump with back-pressure, late samples and mid-dump reset.
module tb_lbp_hist;

  localparam int CNT_W = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             lbp_finish;
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic             hist_last;
  logic             hist_done;
  logic [CNT_W-1:0] total_count;
  logic             border_err;
  logic             late_err;
  logic [1:0]       dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [CNT_W-1:0] exp_bins [256];
  logic [CNT_W-1:0] exp_total;

  lbp_hist #(.CNT_W(CNT_W), .IMG_W(128)) dut (
    .clk(clk), .reset(reset),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .lbp_finish(lbp_finish),
    .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_bin(hist_bin),
    .hist_count(hist_count), .hist_last(hist_last), .hist_done(hist_done),
    .total_count(total_count), .border_err(border_err), .late_err(late_err),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_bins[i] = '0;
    exp_total = '0;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    lbp_valid  = 1'b0;
    lbp_addr   = 14'd0;
    lbp_data   = 8'd0;
    lbp_finish = 1'b0;
    hist_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_exp();
  endtask

  // One sample, presented for exactly one rising edge.
  task automatic send(input logic [13:0] a, input logic [7:0] d);
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    @(negedge clk);
    lbp_valid = 1'b0;
  endtask

  // Drains the dump and checks every word against exp_bins.
  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  // inject_at >= 0 drives a late sample on that dump cycle.
  task automatic run_dump(input int mode, input int inject_at);
    int k = 0;
    int cyc = 0;
    logic rdy;
    logic prev_hold = 1'b0;
    logic [7:0] prev_bin = 8'd0;
    logic [CNT_W-1:0] prev_cnt = '0;
    while (k < 256 && cyc < 2000) begin
      @(negedge clk);
      lbp_valid = 1'b0;
      n_cmp++;
      if (hist_valid !== 1'b1) begin
        n_err++; $display("FAIL dump_valid cyc=%0d got=%b want=1", cyc, hist_valid);
      end
      n_cmp++;
      if (hist_bin !== k[7:0]) begin
        n_err++; $display("FAIL dump_bin cyc=%0d got=%0d want=%0d", cyc, hist_bin, k);
      end
      n_cmp++;
      if (hist_count !== exp_bins[k]) begin
        n_err++; $display("FAIL dump_count bin=%0d got=%0d want=%0d", k, hist_count, exp_bins[k]);
      end
      n_cmp++;
      if (hist_last !== (k == 255)) begin
        n_err++; $display("FAIL dump_last bin=%0d got=%b want=%b", k, hist_last, (k == 255));
      end
      if (prev_hold) begin
        n_cmp++;
        if (hist_bin !== prev_bin || hist_count !== prev_cnt) begin
          n_err++; $display("FAIL dump_hold got=%0d/%0d want=%0d/%0d", hist_bin, hist_count, prev_bin, prev_cnt);
        end
      end
      if (cyc == inject_at) begin
        lbp_valid = 1'b1;
        lbp_addr  = 14'd129;
        lbp_data  = 8'd3;
      end
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      hist_ready = rdy;
      prev_hold  = !rdy;
      prev_bin   = hist_bin;
      prev_cnt   = hist_count;
      if (rdy) k++;
      cyc++;
    end
    n_cmp++;
    if (k != 256) begin
      n_err++; $display("FAIL dump_timeout words=%0d want=256", k);
    end
    if (mode == 0) begin
      n_cmp++;
      if (cyc != 256) begin
        n_err++; $display("FAIL dump_cycles got=%0d want=256", cyc);
      end
    end
    @(negedge clk);
    lbp_valid  = 1'b0;
    hist_ready = 1'b0;
    n_cmp++;
    if (hist_done !== 1'b1 || hist_valid !== 1'b0 || dbg_state !== 2'd2) begin
      n_err++; $display("FAIL done_state got done=%b valid=%b st=%0d want 1/0/2", hist_done, hist_valid, dbg_state);
    end
    n_cmp++;
    if (total_count !== exp_total) begin
      n_err++; $display("FAIL total_after_dump got=%0d want=%0d", total_count, exp_total);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (hist_valid !== 1'b0 || hist_done !== 1'b0 || hist_last !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got valid=%b done=%b last=%b want 0/0/0", hist_valid, hist_done, hist_last);
    end
    n_cmp++;
    if (total_count !== '0) begin
      n_err++; $display("FAIL reset_total got=%0d want=0", total_count);
    end
    n_cmp++;
    if (border_err !== 1'b0 || late_err !== 1'b0) begin
      n_err++; $display("FAIL reset_errs got=%b%b want=00", border_err, late_err);
    end
    n_cmp++;
    if (dbg_state !== 2'd0 || hist_bin !== 8'd0 || hist_count !== '0) begin
      n_err++; $display("FAIL reset_state got st=%0d bin=%0d cnt=%0d want 0/0/0", dbg_state, hist_bin, hist_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send(14'd129, 8'd5);
    send(14'd130, 8'd5);
    send(14'd200, 8'hFF);
    exp_bins[5] = 14'd2; exp_bins[255] = 14'd1; exp_total = 14'd3;
    n_cmp++;
    if (total_count !== 14'd3 || dbg_state !== 2'd0 || hist_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_accum got tot=%0d st=%0d valid=%b want 3/0/0", total_count, dbg_state, hist_valid);
    end
    lbp_finish = 1'b1;
    run_dump(0, -1);
    n_cmp++;
    if (late_err !== 1'b0 || border_err !== 1'b0) begin
      n_err++; $display("FAIL basic_errs got=%b%b want=00", border_err, late_err);
    end
  endtask

  task automatic test_border();
    do_reset();
    send(14'd0, 8'd1);
    send(14'd127, 8'd2);
    send(14'd128, 8'd3);
    send(14'd16383, 8'd4);
    n_cmp++;
    if (border_err !== 1'b1 || total_count !== '0) begin
      n_err++; $display("FAIL border_reject got err=%b tot=%0d want 1/0", border_err, total_count);
    end
    send(14'd129, 8'd9);
    n_cmp++;
    if (total_count !== 14'd1) begin
      n_err++; $display("FAIL border_interior got=%0d want=1", total_count);
    end
    exp_bins[9] = 14'd1; exp_total = 14'd1;
    lbp_finish = 1'b1;
    run_dump(0, -1);
  endtask

  task automatic test_saturation();
    do_reset();
    lbp_valid = 1'b1;
    lbp_addr  = 14'd129;
    lbp_data  = 8'd7;
    repeat (16384) @(negedge clk);
    lbp_valid = 1'b0;
    n_cmp++;
    if (total_count !== 14'd16383) begin
      n_err++; $display("FAIL sat_total got=%0d want=16383", total_count);
    end
    exp_bins[7] = 14'd16383; exp_total = 14'd16383;
    lbp_finish = 1'b1;
    run_dump(0, -1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(14'd129, 8'd0);
    send(14'd300, 8'd1);
    lbp_valid  = 1'b1;
    lbp_addr   = 14'd131;
    lbp_data   = 8'd1;
    lbp_finish = 1'b1;
    exp_bins[0] = 14'd1; exp_bins[1] = 14'd2; exp_total = 14'd3;
    run_dump(1, 1);
    n_cmp++;
    if (late_err !== 1'b1 || border_err !== 1'b0) begin
      n_err++; $display("FAIL late_flag got late=%b border=%b want 1/0", late_err, border_err);
    end
  endtask

  task automatic test_reset_mid_dump();
    int words = 0;
    int cyc = 0;
    do_reset();
    send(14'd129, 8'd200);
    lbp_finish = 1'b1;
    hist_ready = 1'b1;
    while (words < 3 && cyc < 50) begin
      @(negedge clk);
      if (hist_valid) words++;
      cyc++;
    end
    n_cmp++;
    if (words != 3) begin
      n_err++; $display("FAIL mid_timeout words=%0d want=3", words);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (hist_valid !== 1'b0 || dbg_state !== 2'd0 || hist_bin !== 8'd0 || hist_count !== '0) begin
      n_err++; $display("FAIL mid_abort got valid=%b st=%0d bin=%0d cnt=%0d want 0/0/0/0", hist_valid, dbg_state, hist_bin, hist_count);
    end
    n_cmp++;
    if (total_count !== '0 || hist_done !== 1'b0) begin
      n_err++; $display("FAIL mid_regs got tot=%0d done=%b want 0/0", total_count, hist_done);
    end
    lbp_finish = 1'b0;
    hist_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_exp();
    send(14'd129, 8'd42);
    exp_bins[42] = 14'd1; exp_total = 14'd1;
    lbp_finish = 1'b1;
    run_dump(0, -1);
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_basic();
    test_border();
    test_saturation();
    test_back_to_back();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
